// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Unsigned integer divider for the halfdiv datapath. Produces one quotient
// bit per clock using the restoring algorithm. A single WIDTH+1-bit
// borrow-ripple subtract-and-select row is reused for every iteration.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (aborts any operation)
//   start        request, sampled only while idle
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   busy         high while an operation is in RUN or DONE
//   done         one-cycle pulse; quotient/remainder valid from this cycle on
//   quotient     floor(dividend / divisor), all ones on divide-by-zero
//   remainder    dividend mod divisor, the dividend on divide-by-zero
//   div_by_zero  high with done when the captured divisor was zero
//
// Latency from the accepting edge: WIDTH+1 edges until done is sampled high
// (one edge on the divide-by-zero path). quotient and remainder hold their
// values until the next accepted start; mid-operation values are don't-care.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   divisor_q;
  // Partial remainder. After every iteration it is below the divisor, so
  // WIDTH bits are enough to hold it; the extra bit only exists in the trial.
  logic [WIDTH-1:0]   rem_q;

  // During RUN the quotient register doubles as the dividend shift register:
  // dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               borrow_out;

  assign remainder = rem_q;

  // Subtract-and-select row: trial - {1'b0, divisor} with an explicit
  // borrow ripple. Only the low WIDTH difference bits are kept, because a
  // successful subtraction always leaves a result smaller than the divisor.
  always_comb begin
    logic bw;
    // NOTE: every variable is given a value before any conditional use so
    // no latch can be inferred.
    trial      = {rem_q, quotient[WIDTH-1]};
    diff       = '0;
    bw         = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = trial[i] ^ divisor_q[i] ^ bw;
      bw      = (~trial[i] & divisor_q[i]) | (~(trial[i] ^ divisor_q[i]) & bw);
    end
    // Top subtrahend bit is the zero extension, so only the borrow ripples.
    borrow_out = ~trial[WIDTH] & bw;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including the operand and result holding
      // registers, is reset because reset state of quotient/remainder is
      // visible at the outputs.
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            divisor_q <= divisor;
            busy      <= 1'b1;
            if (divisor == '0) begin
              // Divide-by-zero: finish immediately with saturated quotient.
              quotient    <= '1;
              rem_q       <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              quotient    <= dividend;
              rem_q       <= '0;
              div_by_zero <= 1'b0;
              count       <= '0;
              state       <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // Restore (keep the trial) on borrow, otherwise keep the difference.
          // When a borrow occurs the trial is below the divisor, so its top
          // bit is zero and dropping it loses nothing.
          rem_q    <= borrow_out ? trial[WIDTH-1:0] : diff;
          quotient <= {quotient[WIDTH-2:0], ~borrow_out};
          count    <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // Results stay in quotient/rem_q until the next accepted start.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Two divider instances: WIDTH=8 (directed scenarios, checked every cycle
// against a transaction-level model) and WIDTH=16 (directed plus random
// operations checked against / and %). Hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, busy8, done8, dbz8;
  logic [7:0] dv8, ds8, q8, r8;

  logic        start16, busy16, done16, dbz16;
  logic [15:0] dv16, ds16, q16, r16;

  seq_restoring_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dv8), .divisor(ds8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8)
  );

  seq_restoring_divider #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dv16), .divisor(ds16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(dbz16)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Transaction-level model of the 8-bit instance: an accepted start fixes
  // the result with / and %, and done appears after a fixed latency.
  // ------------------------------------------------------------------------
  logic       m_busy, m_done, m_dbz;
  logic [7:0] m_q, m_r;
  int         m_wait;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_wait <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start8) begin
        m_busy <= 1'b1;
        if (ds8 == 8'd0) begin
          m_q    <= 8'hFF;
          m_r    <= dv8;
          m_dbz  <= 1'b1;
          m_done <= 1'b1;
          m_wait <= 0;
        end else begin
          m_q    <= dv8 / ds8;
          m_r    <= dv8 % ds8;
          m_dbz  <= 1'b0;
          m_wait <= 8;
        end
      end
    end else if (m_done) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_wait == 1) begin
      m_done <= 1'b1;
      m_wait <= 0;
    end else begin
      m_wait <= m_wait - 1;
    end
  end

  bit armed = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      check("busy8", busy8, m_busy);
      check("done8", done8, m_done);
      check("dbz8", dbz8, m_dbz);
      if (!m_busy || m_done) begin
        check("quotient8", q8, m_q);
        check("remainder8", r8, m_r);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  // Returns just after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    start8 = 1'b1;
    dv8    = a;
    ds8    = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    dv8    = 8'($urandom);
    ds8    = 8'($urandom);
  endtask

  // n = edges after the accepting edge before done is visible;
  // done is therefore sampled high n+1 edges after acceptance.
  task automatic wait_done8(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) break;
      n++;
    end
    check("done8_seen", done8, 1'b1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    int n;
    @(posedge clk);
    #1;
    start16 = 1'b1;
    dv16    = a;
    ds16    = b;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    dv16    = 16'($urandom);
    ds16    = 16'($urandom);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done16) break;
      n++;
    end
    check("done16_seen", done16, 1'b1);
    check("latency16", n + 1, (b == 16'd0) ? 1 : 17);
    check("quotient16", q16, (b == 16'd0) ? 16'hFFFF : a / b);
    check("remainder16", r16, (b == 16'd0) ? a : a % b);
    check("dbz16", dbz16, b == 16'd0);
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
  } vec_t;

  vec_t vecs[7];

  // ------------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------------
  initial begin
    int n;
    int extra;

    rst     = 1'b1;
    start8  = 1'b0;
    dv8     = '0;
    ds8     = '0;
    start16 = 1'b0;
    dv16    = '0;
    ds16    = '0;

    vecs[0] = '{100, 7, 14, 2, 0, 9};
    vecs[1] = '{5, 9, 0, 5, 0, 9};
    vecs[2] = '{255, 1, 255, 0, 0, 9};
    vecs[3] = '{255, 255, 1, 0, 0, 9};
    vecs[4] = '{37, 0, 255, 37, 1, 1};
    vecs[5] = '{10, 3, 3, 1, 0, 9};
    vecs[6] = '{0, 200, 0, 0, 0, 9};

    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_quotient", q8, 8'd0);
    check("rst_remainder", r8, 8'd0);
    check("rst_dbz", dbz8, 1'b0);
    check("rst_busy16", busy16, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors with hand-computed results and latency.
    foreach (vecs[i]) begin
      issue8(8'(vecs[i].a), 8'(vecs[i].b));
      wait_done8(n);
      check("vec_latency", n + 1, vecs[i].lat);
      check("vec_quotient", q8, vecs[i].q);
      check("vec_remainder", r8, vecs[i].r);
      check("vec_dbz", dbz8, vecs[i].z);
    end

    // start pulses during RUN and DONE must be dropped.
    issue8(8'd200, 8'd9);
    @(posedge clk);
    @(posedge clk);
    #1;
    start8 = 1'b1;
    dv8    = 8'd50;
    ds8    = 8'd5;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    dv8    = 8'd77;
    ds8    = 8'd0;
    wait_done8(n);
    check("ignore_quotient", q8, 8'd22);
    check("ignore_remainder", r8, 8'd2);
    start8 = 1'b1;
    dv8    = 8'd50;
    ds8    = 8'd5;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    extra  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("single_done", extra, 0);
    check("hold_quotient", q8, 8'd22);

    // Reset in the 4th RUN cycle aborts the operation.
    issue8(8'd200, 8'd9);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_quotient", q8, 8'd0);
    check("abort_remainder", r8, 8'd0);
    #1;
    rst = 1'b0;
    issue8(8'd9, 8'd4);
    wait_done8(n);
    check("restart_latency", n + 1, 9);
    check("restart_quotient", q8, 8'd2);
    check("restart_remainder", r8, 8'd1);

    // 16-bit instance.
    run16(16'd65535, 16'd255);
    check("w16_quotient_lit", q16, 16'd257);
    check("w16_remainder_lit", r16, 16'd0);
    run16(16'd1234, 16'd0);
    check("w16_dbz_lit", q16, 16'hFFFF);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      case (i % 4)
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      run16(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
